// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Four-digit seven-segment scan controller. A prescaler divides clk into a
// per-digit refresh slot of REFRESH_DIV cycles. The active-low one-hot digit
// select rotates 1110 -> 1101 -> 1011 -> 0111. A double-buffered 16-bit
// display value is committed only on frame boundaries, or at any time while
// the scan is parked, so a digit never tears mid-frame.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit stays lit (>= 2)
//   DIV_W       : prescaler width, 2**DIV_W >= REFRESH_DIV
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable; 0 blanks the display and parks the scan
//   value_in   in   [15:0] new display value, sampled when load = 1
//   load       in   one-cycle request to update the display
//   digit_sel  out  [3:0] registered active-low digit select (1111 = off)
//   disp_val   out  [15:0] registered committed display value
//   load_ack   out  one-cycle pulse when a pending load commits
//   frame_tick out  one-cycle pulse when the scan wraps from digit 3 to 0
//
// Build option
//   SEG_LZ_BLANK_EN : when defined, digits 1..3 are forced off while the
//                     committed value has only zeros at and above them.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic [3:0]  digit_sel,
  output logic [15:0] disp_val,
  output logic        load_ack,
  output logic        frame_tick
);

  localparam logic [DIV_W-1:0] PRESC_TERM = DIV_W'(REFRESH_DIV - 1);

  // ST_PARK: en low (or just out of reset); the next enabled edge lights
  // digit 0 without counting, so digit 0 gets a full refresh slot.
  typedef enum logic {
    ST_PARK,
    ST_SCAN
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  presc;
  logic [1:0]        dig_idx;
  logic [15:0]       shadow;
  logic              pending;

  logic              presc_term;
  logic              slot_end;
  logic              wrap;
  logic              commit;
  logic [1:0]        idx_nxt;
  logic [3:0]        blank_mask;

  // Active-low one-hot select for a digit index.
  function automatic logic [3:0] sel_decode(input logic [1:0] idx);
    logic [3:0] sel;
    sel = 4'b1111;
    case (idx)
      2'd0:    sel = 4'b1110;
      2'd1:    sel = 4'b1101;
      2'd2:    sel = 4'b1011;
      default: sel = 4'b0111;
    endcase
    return sel;
  endfunction

  always_comb begin
    presc_term = (presc == PRESC_TERM);
    slot_end   = en && (state == ST_SCAN) && presc_term;
    wrap       = slot_end && (dig_idx == 2'd3);
    // While parked every edge is a safe commit point: nothing is lit.
    commit     = !en || wrap;
    idx_nxt    = dig_idx;
    if (slot_end) begin
      idx_nxt = dig_idx + 2'd1;
    end
  end

  // Bit k set forces digit k dark; bit 0 is never set so digit 0 always shows.
  always_comb begin
    blank_mask = 4'b0000;
`ifdef SEG_LZ_BLANK_EN
    blank_mask[1] = (disp_val[15:4]  == 12'h000);
    blank_mask[2] = (disp_val[15:8]  == 8'h00);
    blank_mask[3] = (disp_val[15:12] == 4'h0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PARK;
      presc      <= '0;
      dig_idx    <= 2'd0;
      digit_sel  <= 4'b1111;
      frame_tick <= 1'b0;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      disp_val   <= 16'h0000;
      load_ack   <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;

      // Scan sequencing
      if (!en) begin
        state     <= ST_PARK;
        presc     <= '0;
        dig_idx   <= 2'd0;
        digit_sel <= 4'b1111;
      end else if (state == ST_PARK) begin
        state     <= ST_SCAN;
        presc     <= '0;
        dig_idx   <= 2'd0;
        digit_sel <= sel_decode(2'd0) | blank_mask;
      end else begin
        presc      <= presc_term ? '0 : presc + DIV_W'(1);
        dig_idx    <= idx_nxt;
        digit_sel  <= sel_decode(idx_nxt) | blank_mask;
        frame_tick <= wrap;
      end

      // Double buffer: commit the old shadow first, a simultaneous load
      // refills it and keeps pending set for the next commit point.
      if (commit && pending) begin
        disp_val <= shadow;
        load_ack <= 1'b1;
      end
      if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed bench for seg_scan_ctrl with REFRESH_DIV = 4 (16-cycle frame).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// `ph` is the number of enabled edges since the scan left park; slot = ph/4.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_sel;
  logic [15:0] disp_val;
  logic        load_ack;
  logic        frame_tick;

  int vectors;
  int miscompares;
  int ph;
  int ack_cnt;
  bit bl;

  seg_scan_ctrl #(
    .REFRESH_DIV(4),
    .DIV_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .value_in  (value_in),
    .load      (load),
    .digit_sel (digit_sel),
    .disp_val  (disp_val),
    .load_ack  (load_ack),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (ph=%0d)", tag, obs, exp, ph);
    end
  endtask

  // Expected select for the slot containing ph; blanked slots read 1111.
  function automatic logic [3:0] exp_sel(input int p, input bit blank);
    logic [3:0] tbl [4];
    int slot;
    tbl[0] = 4'b1110;
    tbl[1] = 4'b1101;
    tbl[2] = 4'b1011;
    tbl[3] = 4'b0111;
    slot = (p / 4) % 4;
    if (blank && slot != 0) return 4'b1111;
    return tbl[slot];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (load_ack === 1'b1) ack_cnt++;
  endtask

  // First enabled edge out of park: digit 0 lights, no frame tick.
  task automatic start_scan(input bit blank);
    en = 1'b1;
    tick();
    ph = 0;
    chk("start_sel", 16'(digit_sel), 16'(exp_sel(0, blank)));
    chk("start_ftick", 16'(frame_tick), 16'h0);
  endtask

  task automatic adv(input int n, input bit blank);
    for (int i = 0; i < n; i++) begin
      tick();
      ph++;
      chk("scan_sel", 16'(digit_sel), 16'(exp_sel(ph, blank)));
      chk("scan_ftick", 16'(frame_tick), 16'((ph % 16) == 0));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ph          = 0;
    ack_cnt     = 0;
`ifdef SEG_LZ_BLANK_EN
    bl = 1'b1;
`else
    bl = 1'b0;
`endif
    rst_n    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;

    // Reset values
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_sel", 16'(digit_sel), 16'hF);
    chk("rst_disp", disp_val, 16'h0000);
    chk("rst_ack", 16'(load_ack), 16'h0);
    chk("rst_ftick", 16'(frame_tick), 16'h0);

    // Release with en = 1, two full frames of scan
    rst_n = 1'b1;
    start_scan(1'b0);
    adv(31, 1'b0);

    // Load 0xBEEF during digit 1, commits at the next wrap
    adv(5, 1'b0);                       // ph 36: digit 1
    ack_cnt  = 0;
    load     = 1'b1;
    value_in = 16'hBEEF;
    adv(1, 1'b0);
    load     = 1'b0;
    chk("scan_load_hold0", disp_val, 16'h0000);
    adv(10, 1'b0);                      // ph 47: last cycle before wrap
    chk("scan_load_hold1", disp_val, 16'h0000);
    chk("scan_load_noack", 16'(ack_cnt), 16'd0);
    adv(1, 1'b0);                       // ph 48: wrap
    chk("scan_load_disp", disp_val, 16'hBEEF);
    chk("scan_load_ack", 16'(load_ack), 16'h1);
    adv(1, 1'b0);
    chk("scan_load_ack_drop", 16'(load_ack), 16'h0);
    chk("scan_load_ackcnt", 16'(ack_cnt), 16'd1);

    // Last load wins: 0x1111 then 0x2222 in one frame
    ack_cnt  = 0;
    load     = 1'b1;
    value_in = 16'h1111;
    adv(1, 1'b0);                       // ph 50
    load     = 1'b0;
    adv(6, 1'b0);                       // ph 56
    load     = 1'b1;
    value_in = 16'h2222;
    adv(1, 1'b0);                       // ph 57
    load     = 1'b0;
    adv(6, 1'b0);                       // ph 63
    chk("llw_hold", disp_val, 16'hBEEF);
    adv(1, 1'b0);                       // ph 64: wrap
    chk("llw_disp", disp_val, 16'h2222);
    chk("llw_ack", 16'(load_ack), 16'h1);
    adv(1, 1'b0);
    chk("llw_ackcnt", 16'(ack_cnt), 16'd1);

    // Load 0x0ABC on a wrap edge while 0x5555 is pending
    ack_cnt  = 0;
    load     = 1'b1;
    value_in = 16'h5555;
    adv(1, 1'b0);                       // ph 66
    load     = 1'b0;
    adv(13, 1'b0);                      // ph 79
    load     = 1'b1;
    value_in = 16'h0ABC;
    adv(1, 1'b0);                       // ph 80: wrap, load coincident
    load     = 1'b0;
    chk("cel_disp0", disp_val, 16'h5555);
    chk("cel_ack0", 16'(load_ack), 16'h1);
    adv(15, 1'b0);                      // ph 95
    chk("cel_hold", disp_val, 16'h5555);
    adv(1, 1'b0);                       // ph 96: wrap
    chk("cel_disp1", disp_val, 16'h0ABC);
    chk("cel_ack1", 16'(load_ack), 16'h1);
    adv(1, 1'b0);
    chk("cel_ackcnt", 16'(ack_cnt), 16'd2);

    // Load while disabled: commits on the following edge
    en = 1'b0;
    tick();
    chk("dis_sel", 16'(digit_sel), 16'hF);
    chk("dis_ftick", 16'(frame_tick), 16'h0);
    load     = 1'b1;
    value_in = 16'h1234;
    tick();
    load     = 1'b0;
    chk("dis_disp_before", disp_val, 16'h0ABC);
    chk("dis_ack_before", 16'(load_ack), 16'h0);
    tick();
    chk("dis_disp", disp_val, 16'h1234);
    chk("dis_ack", 16'(load_ack), 16'h1);
    chk("dis_sel_off", 16'(digit_sel), 16'hF);
    tick();
    chk("dis_ack_drop", 16'(load_ack), 16'h0);

    // Enable rising: digit 0 held a full slot
    start_scan(1'b0);
    adv(8, 1'b0);
    en = 1'b0;
    tick();
    chk("park_sel", 16'(digit_sel), 16'hF);

    // Display 0x0005: slots 1..3 dark when blanking is built in
    load     = 1'b1;
    value_in = 16'h0005;
    tick();
    load     = 1'b0;
    tick();
    chk("blank5_disp", disp_val, 16'h0005);
    start_scan(bl);
    adv(17, bl);

    // Display 0x0000: digit 0 still lit
    en       = 1'b0;
    load     = 1'b1;
    value_in = 16'h0000;
    tick();
    load     = 1'b0;
    tick();
    chk("blank0_disp", disp_val, 16'h0000);
    start_scan(bl);
    adv(16, bl);

    // Reset mid-frame with a load pending
    en       = 1'b0;
    load     = 1'b1;
    value_in = 16'hBEEF;
    tick();
    load     = 1'b0;
    tick();
    chk("mrst_pre_disp", disp_val, 16'hBEEF);
    start_scan(1'b0);
    adv(5, 1'b0);
    load     = 1'b1;
    value_in = 16'h7777;
    adv(1, 1'b0);
    load     = 1'b0;
    adv(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_sel", 16'(digit_sel), 16'hF);
    chk("mrst_disp", disp_val, 16'h0000);
    chk("mrst_ack", 16'(load_ack), 16'h0);
    chk("mrst_ftick", 16'(frame_tick), 16'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    ack_cnt = 0;
    start_scan(1'b0);
    chk("mrst_restart_disp", disp_val, 16'h0000);
    adv(16, 1'b0);                      // wrap: pending load was dropped
    chk("mrst_wrap_disp", disp_val, 16'h0000);
    chk("mrst_wrap_ack", 16'(ack_cnt), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
